axi4_lite_master: RTL and testbench

AXI4-Lite master that turns single-word read/write requests from the core-side memory controller into AXI4-Lite transactions. It sits between the cache/memory controller and the interconnect, opposite the AXI4-Lite slave that fronts external memory. It runs independent read and write state machines, latches request address and data, and returns read data and completion pulses to the requester.

---
 rtl/axi4_lite_pkg.sv | 35 +++
 rtl/axi4_lite_master_write.sv | 95 +++++++++
 rtl/axi4_lite_master.sv | 142 ++++++++++++++
 tb/tb_axi4_lite_master.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/axi4_lite_pkg.sv
`default_nettype none
// =============================================================================
// axi4_lite_pkg : shared response/state encodings for the AXI4-Lite master
// Rev 1.0
// =============================================================================
package axi4_lite_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axi_resp_e;

  typedef enum logic [1:0] {
    RD_IDLE = 2'b00,
    RD_ADDR = 2'b01,
    RD_DATA = 2'b10
  } rd_state_e;

  typedef enum logic [1:0] {
    WR_IDLE = 2'b00,
    WR_SEND = 2'b01,
    WR_RESP = 2'b10
  } wr_state_e;

  localparam logic [2:0] C_AXI_PROT_DEFAULT = 3'b000;

  // SLVERR and DECERR are exactly the encodings with the upper bit set.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return (resp == SLVERR) || (resp == DECERR);
  endfunction

endpackage
`default_nettype wire

// File: rtl/axi4_lite_master_write.sv
`default_nettype none
// =============================================================================
// axi4_lite_master_write : AW/W/B write channel FSM with independent AW and W handshakes
// Rev 1.0
// =============================================================================
module axi4_lite_master_write
  import axi4_lite_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 64,
  parameter int AXI_DATA_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          arst,
  input  logic                          i_start,
  input  logic [AXI_ADDR_WIDTH-1:0]     i_addr,
  input  logic [AXI_DATA_WIDTH-1:0]     i_data,
  input  logic [AXI_DATA_WIDTH/8-1:0]   i_strb,
  output logic                          o_done,
  output logic                          o_busy,
  output logic                          AW_VALID,
  output logic [AXI_ADDR_WIDTH-1:0]     AW_ADDR,
  output logic [2:0]                    AW_PROT,
  input  logic                          AW_READY,
  output logic                          W_VALID,
  output logic [AXI_DATA_WIDTH-1:0]     W_DATA,
  output logic [AXI_DATA_WIDTH/8-1:0]   W_STRB,
  input  logic                          W_READY,
  input  logic                          B_VALID,
  output logic                          B_READY
);

  wr_state_e                   r_state;
  wr_state_e                   w_state_nxt;
  logic                        r_aw_done;
  logic                        r_w_done;
  logic                        r_done;
  logic [AXI_ADDR_WIDTH-1:0]   r_addr;
  logic [AXI_DATA_WIDTH-1:0]   r_data;
  logic [AXI_DATA_WIDTH/8-1:0] r_strb;
  logic                        w_aw_fin;
  logic                        w_w_fin;

  // A channel counts as finished if it handshook earlier or is handshaking now.
  assign w_aw_fin = r_aw_done || (AW_VALID && AW_READY);
  assign w_w_fin  = r_w_done  || (W_VALID && W_READY);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      WR_IDLE: if (i_start)             w_state_nxt = WR_SEND;
      WR_SEND: if (w_aw_fin && w_w_fin) w_state_nxt = WR_RESP;
      WR_RESP: if (B_VALID)             w_state_nxt = WR_IDLE;
      default:                          w_state_nxt = WR_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_state   <= WR_IDLE;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_done    <= 1'b0;
      r_addr    <= '0;
      r_data    <= '0;
      r_strb    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= (r_state == WR_RESP) && B_VALID;
      if (r_state == WR_IDLE && i_start) begin
        r_addr <= i_addr;
        r_data <= i_data;
        r_strb <= i_strb;
      end
      if (r_state == WR_SEND && w_state_nxt == WR_SEND) begin
        r_aw_done <= w_aw_fin;
        r_w_done  <= w_w_fin;
      end else begin
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
      end
    end
  end

  assign AW_VALID = (r_state == WR_SEND) && !r_aw_done;
  assign W_VALID  = (r_state == WR_SEND) && !r_w_done;
  assign B_READY  = (r_state == WR_RESP);
  assign AW_ADDR  = r_addr;
  assign AW_PROT  = C_AXI_PROT_DEFAULT;
  assign W_DATA   = r_data;
  assign W_STRB   = r_strb;
  assign o_done   = r_done;
  assign o_busy   = (r_state != WR_IDLE);

endmodule
`default_nettype wire

// File: rtl/axi4_lite_master.sv
`default_nettype none
// =============================================================================
// axi4_lite_master : single-word AXI4-Lite master, inline read FSM + write sub-module
// Optional response checking via macro AXI_RESP_CHECK_EN.  Rev 1.0
// =============================================================================
module axi4_lite_master
  import axi4_lite_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 64,
  parameter int AXI_DATA_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          arst,
  input  logic                          i_start_read,
  input  logic                          i_start_write,
  input  logic [AXI_ADDR_WIDTH-1:0]     i_addr,
  input  logic [AXI_DATA_WIDTH-1:0]     i_data,
  input  logic [AXI_DATA_WIDTH/8-1:0]   i_strb,
  output logic [AXI_DATA_WIDTH-1:0]     o_data,
  output logic                          o_read_done,
  output logic                          o_write_done,
  output logic                          o_read_busy,
  output logic                          o_write_busy,
`ifdef AXI_RESP_CHECK_EN
  output logic                          o_resp_err,
`endif
  output logic                          AR_VALID,
  output logic [AXI_ADDR_WIDTH-1:0]     AR_ADDR,
  output logic [2:0]                    AR_PROT,
  input  logic                          AR_READY,
  input  logic [AXI_DATA_WIDTH-1:0]     R_DATA,
  input  logic [1:0]                    R_RESP,
  input  logic                          R_VALID,
  output logic                          R_READY,
  output logic                          AW_VALID,
  output logic [AXI_ADDR_WIDTH-1:0]     AW_ADDR,
  output logic [2:0]                    AW_PROT,
  input  logic                          AW_READY,
  output logic                          W_VALID,
  output logic [AXI_DATA_WIDTH-1:0]     W_DATA,
  output logic [AXI_DATA_WIDTH/8-1:0]   W_STRB,
  input  logic                          W_READY,
  input  logic [1:0]                    B_RESP,
  input  logic                          B_VALID,
  output logic                          B_READY
);

  rd_state_e                 r_rstate;
  rd_state_e                 w_rstate_nxt;
  logic [AXI_ADDR_WIDTH-1:0] r_araddr;
  logic [AXI_DATA_WIDTH-1:0] r_rdata;
  logic                      r_read_done;
  logic                      w_ar_accept;
  logic                      w_r_hs;

  assign w_ar_accept = (r_rstate == RD_IDLE) && i_start_read;
  assign w_r_hs      = (r_rstate == RD_DATA) && R_VALID;

  always_comb begin
    w_rstate_nxt = r_rstate;
    case (r_rstate)
      RD_IDLE: if (i_start_read) w_rstate_nxt = RD_ADDR;
      RD_ADDR: if (AR_READY)     w_rstate_nxt = RD_DATA;
      RD_DATA: if (R_VALID)      w_rstate_nxt = RD_IDLE;
      default:                   w_rstate_nxt = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_rstate    <= RD_IDLE;
      r_araddr    <= '0;
      r_rdata     <= '0;
      r_read_done <= 1'b0;
    end else begin
      r_rstate    <= w_rstate_nxt;
      r_read_done <= w_r_hs;
      if (w_ar_accept) r_araddr <= i_addr;
      if (w_r_hs)      r_rdata  <= R_DATA;
    end
  end

  assign AR_VALID    = (r_rstate == RD_ADDR);
  assign R_READY     = (r_rstate == RD_DATA);
  assign AR_ADDR     = r_araddr;
  assign AR_PROT     = C_AXI_PROT_DEFAULT;
  assign o_data      = r_rdata;
  assign o_read_done = r_read_done;
  assign o_read_busy = (r_rstate != RD_IDLE);

  axi4_lite_master_write #(
    .AXI_ADDR_WIDTH (AXI_ADDR_WIDTH),
    .AXI_DATA_WIDTH (AXI_DATA_WIDTH)
  ) u_write (
    .clk      (clk),
    .arst     (arst),
    .i_start  (i_start_write),
    .i_addr   (i_addr),
    .i_data   (i_data),
    .i_strb   (i_strb),
    .o_done   (o_write_done),
    .o_busy   (o_write_busy),
    .AW_VALID (AW_VALID),
    .AW_ADDR  (AW_ADDR),
    .AW_PROT  (AW_PROT),
    .AW_READY (AW_READY),
    .W_VALID  (W_VALID),
    .W_DATA   (W_DATA),
    .W_STRB   (W_STRB),
    .W_READY  (W_READY),
    .B_VALID  (B_VALID),
    .B_READY  (B_READY)
  );

`ifdef AXI_RESP_CHECK_EN
  logic r_resp_err;
  logic w_err_set;
  logic w_any_start;

  assign w_err_set   = (w_r_hs && resp_is_err(R_RESP)) ||
                       (B_READY && B_VALID && resp_is_err(B_RESP));
  assign w_any_start = w_ar_accept || (i_start_write && !o_write_busy);

  // Sticky until the next accepted start; a new error in that same cycle wins.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_resp_err <= 1'b0;
    end else if (w_err_set) begin
      r_resp_err <= 1'b1;
    end else if (w_any_start) begin
      r_resp_err <= 1'b0;
    end
  end

  assign o_resp_err = r_resp_err;
`else
  logic w_unused_resp;
  assign w_unused_resp = ^{R_RESP, B_RESP};
`endif

endmodule
`default_nettype wire

// File: tb/tb_axi4_lite_master.sv
`default_nettype none
// =============================================================================
// tb_axi4_lite_master : directed self-checking bench for axi4_lite_master
// Rev 1.0
// =============================================================================
module tb_axi4_lite_master;

  localparam int AW = 64;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          arst;
  logic          i_start_read, i_start_write;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_data;
  logic [3:0]    i_strb;
  logic [DW-1:0] o_data;
  logic          o_read_done, o_write_done, o_read_busy, o_write_busy;
`ifdef AXI_RESP_CHECK_EN
  logic          o_resp_err;
`endif
  logic          AR_VALID, AR_READY, R_VALID, R_READY;
  logic [AW-1:0] AR_ADDR, AW_ADDR;
  logic [2:0]    AR_PROT, AW_PROT;
  logic [DW-1:0] R_DATA, W_DATA;
  logic [1:0]    R_RESP, B_RESP;
  logic          AW_VALID, AW_READY, W_VALID, W_READY, B_VALID, B_READY;
  logic [3:0]    W_STRB;

  int n_err = 0;
  int n_chk = 0;
  int n_ar  = 0;

  always #5 clk = ~clk;

  axi4_lite_master #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW)) dut (
    .clk(clk), .arst(arst),
    .i_start_read(i_start_read), .i_start_write(i_start_write),
    .i_addr(i_addr), .i_data(i_data), .i_strb(i_strb),
    .o_data(o_data), .o_read_done(o_read_done), .o_write_done(o_write_done),
    .o_read_busy(o_read_busy), .o_write_busy(o_write_busy),
`ifdef AXI_RESP_CHECK_EN
    .o_resp_err(o_resp_err),
`endif
    .AR_VALID(AR_VALID), .AR_ADDR(AR_ADDR), .AR_PROT(AR_PROT), .AR_READY(AR_READY),
    .R_DATA(R_DATA), .R_RESP(R_RESP), .R_VALID(R_VALID), .R_READY(R_READY),
    .AW_VALID(AW_VALID), .AW_ADDR(AW_ADDR), .AW_PROT(AW_PROT), .AW_READY(AW_READY),
    .W_VALID(W_VALID), .W_DATA(W_DATA), .W_STRB(W_STRB), .W_READY(W_READY),
    .B_RESP(B_RESP), .B_VALID(B_VALID), .B_READY(B_READY)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Inputs are driven and outputs sampled 1 time unit after each rising edge.
  task automatic tick();
    if (AR_VALID && AR_READY) n_ar++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    arst = 1'b1;
    i_start_read = 0; i_start_write = 0; i_addr = '0; i_data = '0; i_strb = '0;
    AR_READY = 0; R_DATA = '0; R_RESP = 2'b00; R_VALID = 0;
    AW_READY = 0; W_READY = 0; B_RESP = 2'b00; B_VALID = 0;
    tick(); tick();
    arst = 1'b0;
    tick();

    // reset state
    chk("rst_valids", {AR_VALID, R_READY, AW_VALID, W_VALID, B_READY}, 5'b0);
    chk("rst_busy_done", {o_read_busy, o_write_busy, o_read_done, o_write_done}, 4'b0);
    chk("rst_odata", o_data, 64'h0);
    chk("rst_addr", AR_ADDR, 64'h0);

    // zero-wait read
    i_start_read = 1; i_addr = 64'h1000;
    AR_READY = 1; R_VALID = 1; R_DATA = 32'hDEADBEEF;
    tick();
    i_start_read = 0; i_addr = 64'h0;
    chk("rd_c1_arvalid", {AR_VALID, R_READY, o_read_busy}, 3'b101);
    chk("rd_c1_araddr", AR_ADDR, 64'h1000);
    chk("rd_c1_arprot", AR_PROT, 64'h0);
    tick();
    chk("rd_c2_rready", {AR_VALID, R_READY, o_read_done}, 3'b010);
    tick();
    chk("rd_c3_done", {o_read_done, o_read_busy}, 2'b10);
    chk("rd_c3_data", o_data, 64'hDEADBEEF);
    R_VALID = 0; R_DATA = 32'h0; AR_READY = 0;
    tick();
    chk("rd_c4_pulse", o_read_done, 64'h0);
    chk("rd_c4_hold", o_data, 64'hDEADBEEF);

    // write with AW_READY delayed, W_READY immediate
    i_start_write = 1; i_addr = 64'h2000; i_data = 32'hCAFEF00D; i_strb = 4'b0011;
    W_READY = 1; AW_READY = 0; B_VALID = 1;
    tick();
    i_start_write = 0; i_data = '0; i_strb = '0; i_addr = '0;
    chk("wr_c1_valid", {AW_VALID, W_VALID, o_write_busy}, 3'b111);
    chk("wr_c1_wdata", W_DATA, 64'hCAFEF00D);
    chk("wr_c1_wstrb", W_STRB, 64'h3);
    tick();
    chk("wr_c2_valid", {AW_VALID, W_VALID, B_READY}, 3'b100);
    tick();
    chk("wr_c3_valid", {AW_VALID, W_VALID, B_READY}, 3'b100);
    tick();
    AW_READY = 1;
    chk("wr_c4_valid", {AW_VALID, W_VALID}, 2'b10);
    chk("wr_c4_awaddr", AW_ADDR, 64'h2000);
    tick();
    AW_READY = 0;
    chk("wr_c5_bready", {AW_VALID, W_VALID, B_READY, o_write_done}, 4'b0010);
    tick();
    chk("wr_c6_done", o_write_done, 64'h1);
    B_VALID = 0; W_READY = 0;
    tick();
    chk("wr_c7_idle", {o_write_done, o_write_busy}, 2'b00);

    // simultaneous read and write
    i_start_read = 1; i_start_write = 1; i_addr = 64'h6000;
    i_data = 32'h11223344; i_strb = 4'hF;
    AR_READY = 1; R_VALID = 1; R_DATA = 32'h0BADF00D;
    AW_READY = 1; W_READY = 1; B_VALID = 1;
    tick();
    i_start_read = 0; i_start_write = 0;
    chk("sim_c1_valids", {AR_VALID, AW_VALID, W_VALID}, 3'b111);
    tick();
    chk("sim_c2_readys", {R_READY, B_READY}, 2'b11);
    tick();
    chk("sim_c3_dones", {o_read_done, o_write_done}, 2'b11);
    chk("sim_c3_data", o_data, 64'h0BADF00D);
    AR_READY = 0; R_VALID = 0; AW_READY = 0; W_READY = 0; B_VALID = 0;
    tick();

    // repeated start while AR stalled
    n_ar = 0;
    i_start_read = 1; i_addr = 64'h3000;
    tick();
    i_addr = 64'h4444;
    chk("stall_c1_arvalid", AR_VALID, 64'h1);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("stall_araddr", {AR_VALID, AR_ADDR}, {1'b1, 64'h3000});
    end
    AR_READY = 1; i_start_read = 0; R_VALID = 1; R_DATA = 32'h12345678;
    tick();
    AR_READY = 0;
    chk("stall_rready", {AR_VALID, R_READY}, 2'b01);
    tick();
    chk("stall_done", o_read_done, 64'h1);
    chk("stall_data", o_data, 64'h12345678);
    R_VALID = 0;
    tick(); tick();
    chk("stall_one_ar", n_ar, 64'h1);
    chk("stall_idle", {AR_VALID, o_read_busy}, 2'b00);

    // async reset while in R_DATA
    i_start_read = 1; i_addr = 64'h7000; AR_READY = 1; R_VALID = 0;
    tick();
    i_start_read = 0;
    tick();
    chk("arst_pre_rready", R_READY, 64'h1);
    arst = 1'b1;
    #1;
    chk("arst_imm", {R_READY, o_read_busy, o_read_done}, 3'b000);
    tick();
    chk("arst_no_done", o_read_done, 64'h0);
    chk("arst_odata", o_data, 64'h0);
    arst = 1'b0;
    tick();
    i_start_read = 1; i_addr = 64'h5000; R_VALID = 1; R_DATA = 32'hA5A5A5A5;
    tick();
    i_start_read = 0;
    chk("post_rst_araddr", {AR_VALID, AR_ADDR}, {1'b1, 64'h5000});
    tick(); tick();
    chk("post_rst_done", o_read_done, 64'h1);
    chk("post_rst_data", o_data, 64'hA5A5A5A5);
    AR_READY = 0; R_VALID = 0;
    tick();

`ifdef AXI_RESP_CHECK_EN
    i_start_write = 1; i_addr = 64'h8000; i_data = 32'h1; i_strb = 4'h1;
    AW_READY = 1; W_READY = 1; B_VALID = 1; B_RESP = 2'b10;
    tick();
    i_start_write = 0;
    chk("err_c1", o_resp_err, 64'h0);
    tick(); tick();
    chk("err_set", {o_write_done, o_resp_err}, 2'b11);
    B_VALID = 0; B_RESP = 2'b00;
    tick();
    chk("err_sticky", o_resp_err, 64'h1);
    i_start_read = 1; AR_READY = 1; R_VALID = 1;
    tick();
    i_start_read = 0;
    chk("err_clear", o_resp_err, 64'h0);
    tick(); tick();
    AR_READY = 0; R_VALID = 0; AW_READY = 0; W_READY = 0;
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
